// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared fetch-unit types: FSM states, default address width, argc helper
package instr_fetch_pkg;

    localparam int DEFAULT_ADDR_W = 12;

    typedef enum logic [2:0] {
        OP_ADDR  = 3'd0,
        OP_LATCH = 3'd1,
        DECODE   = 3'd2,
        ARG1     = 3'd3,
        ARG2     = 3'd4,
        VALID    = 3'd5,
        HALT     = 3'd6
    } fetch_state_t;

    // The reserved argc encoding 2'b11 fetches two argument bytes, like 2'b10.
    function automatic logic [1:0] arg_bytes(input logic [1:0] argc);
        return (argc == 2'b11) ? 2'b10 : argc;
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - bytecode fetch unit: reads opcode and 0-2 argument bytes from a synchronous ROM
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] prog_addr,
    input  logic [7:0]        prog_data,
    output logic [7:0]        opcode,
    input  logic [1:0]        argc,
    output logic [15:0]       args,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              branch,
    input  logic [15:0]       branch_off,
    input  logic              halt,
    output logic              halted
);

    fetch_state_t      state, next_state;
    logic [ADDR_W-1:0] pc;
    logic [1:0]        n_args;
    logic              pc_inc, latch_op, cap_b1, cap_b2, take_branch;

    assign n_args    = arg_bytes(argc);
    // The ROM always sees pc; in VALID/HALT pc is frozen, so the address is stable.
    assign prog_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= OP_ADDR;
        else     state <= next_state;
    end

    always_comb begin
        next_state  = state;
        pc_inc      = 1'b0;
        latch_op    = 1'b0;
        cap_b1      = 1'b0;
        cap_b2      = 1'b0;
        take_branch = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        case (state)
            OP_ADDR:  next_state = OP_LATCH;
            OP_LATCH: begin
                latch_op   = 1'b1;
                pc_inc     = 1'b1;
                next_state = DECODE;
            end
            DECODE: begin
                if (n_args == 2'd0) begin
                    next_state = VALID;
                end else begin
                    pc_inc     = 1'b1;
                    next_state = ARG1;
                end
            end
            ARG1: begin
                cap_b1 = 1'b1;
                if (n_args == 2'd1) begin
                    next_state = VALID;
                end else begin
                    pc_inc     = 1'b1;
                    next_state = ARG2;
                end
            end
            ARG2: begin
                cap_b2     = 1'b1;
                next_state = VALID;
            end
            VALID: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    if (halt) begin
                        next_state = HALT;
                    end else begin
                        take_branch = branch;
                        next_state  = OP_ADDR;
                    end
                end
            end
            HALT:    halted = 1'b1;
            default: next_state = OP_ADDR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= '0;
            opcode   <= 8'h00;
            args     <= 16'h0000;
            instr_pc <= '0;
        end else begin
            // Offset is relative to the opcode byte; truncation gives modulo-2^ADDR_W wrap.
            if (take_branch)
                pc <= ADDR_W'(32'(instr_pc) + 32'(branch_off));
            else if (pc_inc)
                pc <= pc + ADDR_W'(1);
            if (latch_op) begin
                opcode   <= prog_data;
                instr_pc <= pc;
                args     <= 16'h0000;
            end
            if (cap_b1)
                args <= {8'h00, prog_data};
            if (cap_b2)
                args <= {args[7:0], prog_data};
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized self-checking bench for instr_fetch against an instruction-level model
module tb_instr_fetch;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] prog_addr;
    logic [7:0]    prog_data = 8'h00;
    logic [7:0]    opcode;
    logic [1:0]    argc;
    logic [15:0]   args;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic          branch = 1'b0;
    logic [15:0]   branch_off = 16'h0000;
    logic          halt = 1'b0;
    logic          halted;

    logic [7:0]    rom [0:(1<<AW)-1];
    logic [AW-1:0] mpc;
    int            n_checks = 0;
    int            n_pass = 0;

    instr_fetch #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .prog_addr(prog_addr), .prog_data(prog_data),
        .opcode(opcode), .argc(argc), .args(args), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .branch(branch),
        .branch_off(branch_off), .halt(halt), .halted(halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) prog_data <= rom[prog_addr];

    // Stand-in decoder: a few known opcodes, everything else uses its low two bits.
    function automatic logic [1:0] dec_argc(input logic [7:0] op);
        case (op)
            8'h10:        return 2'd1;
            8'h11, 8'ha7: return 2'd2;
            default:      return op[1:0];
        endcase
    endfunction

    assign argc = dec_argc(opcode);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < (1 << AW); i++) rom[i] = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        instr_ready = 1'b0;
        branch = 1'b0;
        halt = 1'b0;
        #1;
        check("reset_outputs", {prog_addr, opcode, args, instr_pc, instr_valid, halted},
              {12'h000, 8'h00, 16'h0000, 12'h000, 1'b0, 1'b0});
        @(negedge clk);
        rst = 1'b0;
        mpc = '0;
    endtask

    // Called at the negedge of the cycle in which the fetch unit sits in OP_ADDR.
    task automatic run_one(input int delay, input logic br, input logic [15:0] off, input logic hl);
        logic [AW-1:0] p, nxt;
        logic [7:0]    op, b1, b2;
        int            n, k;
        logic [15:0]   exp_args;
        p  = mpc;
        op = rom[p];
        b1 = rom[AW'(p + 1)];
        b2 = rom[AW'(p + 2)];
        n  = (dec_argc(op) == 2'd3) ? 2 : int'(dec_argc(op));
        exp_args = (n == 0) ? 16'h0000 : (n == 1) ? {8'h00, b1} : {b1, b2};
        nxt = AW'(p + 1 + n);
        k = 0;
        while (!instr_valid && k < 20) begin
            branch = 1'($urandom);
            halt = 1'($urandom);
            branch_off = 16'($urandom);
            @(negedge clk);
            k++;
        end
        check("latency", 64'(k), 64'(3 + n));
        if (!instr_valid) return;
        check("opcode", opcode, op);
        check("args", args, exp_args);
        check("instr_pc", instr_pc, p);
        check("prog_addr_valid", prog_addr, nxt);
        for (int d = 0; d < delay; d++) begin
            instr_ready = 1'b0;
            branch = 1'($urandom);
            halt = 1'($urandom);
            @(negedge clk);
            check("hold", {instr_valid, opcode, args, instr_pc, prog_addr},
                  {1'b1, op, exp_args, p, nxt});
        end
        instr_ready = 1'b1;
        branch = br;
        branch_off = off;
        halt = hl;
        @(negedge clk);
        instr_ready = 1'b0;
        branch = 1'b0;
        halt = 1'b0;
        mpc = (hl || !br) ? nxt : AW'(p + off[AW-1:0]);
    endtask

    initial begin
        // Two zero-argument opcodes
        clear_rom();
        rom[0] = 8'h04;
        rom[1] = 8'h60;
        do_reset();
        run_one(0, 1'b0, 16'h0, 1'b0);
        run_one(0, 1'b0, 16'h0, 1'b0);

        // sipush with two big-endian argument bytes
        clear_rom();
        rom[0] = 8'h11; rom[1] = 8'h12; rom[2] = 8'h34;
        do_reset();
        run_one(0, 1'b0, 16'h0, 1'b0);
        check("sipush_next_pc", mpc, 12'h003);
        run_one(0, 1'b0, 16'h0, 1'b0);

        // Backward goto from 0x005 lands on 0x000
        clear_rom();
        rom[5] = 8'ha7; rom[6] = 8'hff; rom[7] = 8'hfb;
        do_reset();
        for (int i = 0; i < 5; i++) run_one(0, 1'b0, 16'h0, 1'b0);
        run_one(0, 1'b1, 16'hfffb, 1'b0);
        check("goto_target", mpc, 12'h000);
        run_one(10, 1'b0, 16'h0, 1'b0);
        run_one(0, 1'b0, 16'h0, 1'b0);

        // Address wrap: opcode at 0xFFF with one argument byte at 0x000
        clear_rom();
        rom[0] = 8'h60;
        rom[12'hfff] = 8'h10;
        do_reset();
        run_one(0, 1'b1, 16'hffff, 1'b0);
        run_one(0, 1'b0, 16'h0, 1'b0);
        check("wrap_next_pc", mpc, 12'h001);
        run_one(0, 1'b0, 16'h0, 1'b0);

        // Random program with random stalls and branches, then halt with branch also set
        for (int i = 0; i < (1 << AW); i++) rom[i] = 8'($urandom);
        do_reset();
        for (int i = 0; i < 150; i++)
            run_one($urandom_range(0, 3), ($urandom_range(0, 3) == 0), 16'($urandom), 1'b0);
        run_one(2, 1'b1, 16'($urandom), 1'b1);
        for (int i = 0; i < 20; i++) begin
            instr_ready = 1'($urandom);
            branch = 1'($urandom);
            halt = 1'($urandom);
            @(negedge clk);
            check("halt_hold", {halted, instr_valid, prog_addr}, {1'b1, 1'b0, mpc});
        end

        // Reset during ARG1 discards the partial fetch
        clear_rom();
        rom[0] = 8'h10; rom[1] = 8'h5a;
        do_reset();
        repeat (3) @(negedge clk);
        check("in_arg1", {instr_valid, prog_addr}, {1'b0, 12'h002});
        rst = 1'b1;
        #1;
        check("midreset_outputs", {prog_addr, opcode, args, instr_pc, instr_valid, halted},
              {12'h000, 8'h00, 16'h0000, 12'h000, 1'b0, 1'b0});
        @(negedge clk);
        rst = 1'b0;
        mpc = '0;
        run_one(0, 1'b0, 16'h0, 1'b0);
        run_one(0, 1'b0, 16'h0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
